// File: rtl/uart_tx_sched_pkg.sv
// Shared types for the UART transmit scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DRAIN,
    ST_CFG
  } state_t;

  localparam int unsigned GUARD_CNT_W = 4;
  localparam int unsigned CYC_CNT_W   = 33;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with simultaneous push/pop, plus a look-ahead port exposing the entry behind the head.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         peek_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o  = mem_q[rd_ptr_q];
  assign peek_o  = mem_q[rd_ptr_q + PW'(1)];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin merge of two byte producers into a TX FIFO feeding the UART, with
// baud-divider changes deferred until the last byte has fully left the line.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned CLKDIV     = 139,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GUARD_BITS = 11
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          c0_valid,
  input  logic [7:0]                    c0_data,
  output logic                          c0_ready,
  input  logic                          c1_valid,
  input  logic [7:0]                    c1_data,
  output logic                          c1_ready,
  input  logic                          div_req,
  input  logic [31:0]                   div_val,
  output logic                          div_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_idle,
  output logic                          reg_div_we,
  output logic [31:0]                   reg_div_di,
  output logic                          reg_dat_we,
  output logic [7:0]                    reg_dat_di,
  input  logic                          reg_dat_wait
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t                 state_q;
  logic                   last_grant_q;
  logic                   reg_dat_we_q;
  logic [7:0]             reg_dat_di_q;
  logic                   reg_div_we_q;
  logic [31:0]            reg_div_di_q;
  logic                   div_ack_q;
  logic [31:0]            shadow_div_q;
  logic [GUARD_CNT_W-1:0] bit_cnt_q;
  logic [CYC_CNT_W-1:0]   cyc_cnt_q;
  logic [CYC_CNT_W-1:0]   cyc_cnt_d;

  logic                   gnt0;
  logic                   gnt1;
  logic                   accept;
  logic                   can_push;
  logic                   fifo_push;
  logic [7:0]             push_data;
  logic [7:0]             fifo_head;
  logic [7:0]             fifo_peek;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LVL_W-1:0]       fifo_lvl;
  logic                   guard_expired;
  logic                   more_after_pop;
  logic [7:0]             next_head;

  assign accept   = reg_dat_we_q && !reg_dat_wait;
  assign can_push = !fifo_full || accept;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (can_push) begin
      if (c0_valid && c1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = c0_valid;
        gnt1 = c1_valid;
      end
    end
  end

  assign fifo_push = gnt0 || gnt1;
  assign push_data = gnt1 ? c1_data : c0_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           last_grant_q <= 1'b1;
    else if (gnt0)         last_grant_q <= 1'b0;
    else if (gnt1)         last_grant_q <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (fifo_push),
    .wdata_i (push_data),
    .pop_i   (accept),
    .head_o  (fifo_head),
    .peek_o  (fifo_peek),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_lvl)
  );

  // The head after a pop is the second entry, or the byte being pushed right now if only one remained.
  assign more_after_pop = (fifo_lvl > LVL_W'(1)) || fifo_push;
  assign next_head      = (fifo_lvl > LVL_W'(1)) ? fifo_peek : push_data;

  // One bit period is shadow_div+2 cycles: reload value shadow_div+1 counted down through 0.
  assign cyc_cnt_d     = {1'b0, shadow_div_q} + CYC_CNT_W'(1);
  assign guard_expired = (bit_cnt_q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
    end else if (accept) begin
      bit_cnt_q <= GUARD_CNT_W'(GUARD_BITS);
      cyc_cnt_q <= cyc_cnt_d;
    end else if (!guard_expired) begin
      if (cyc_cnt_q == '0) begin
        bit_cnt_q <= bit_cnt_q - GUARD_CNT_W'(1);
        cyc_cnt_q <= cyc_cnt_d;
      end else begin
        cyc_cnt_q <= cyc_cnt_q - CYC_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      reg_dat_we_q <= 1'b0;
      reg_dat_di_q <= '0;
      reg_div_we_q <= 1'b0;
      reg_div_di_q <= '0;
      div_ack_q    <= 1'b0;
      shadow_div_q <= 32'(CLKDIV);
    end else begin
      reg_div_we_q <= 1'b0;
      reg_div_di_q <= '0;
      div_ack_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (div_req) begin
            state_q <= ST_DRAIN;
          end else if (!fifo_empty) begin
            state_q      <= ST_SEND;
            reg_dat_we_q <= 1'b1;
            reg_dat_di_q <= fifo_head;
          end
        end
        ST_SEND: begin
          if (accept) begin
            if (div_req) begin
              state_q      <= ST_DRAIN;
              reg_dat_we_q <= 1'b0;
            end else if (more_after_pop) begin
              reg_dat_di_q <= next_head;
            end else begin
              state_q      <= ST_IDLE;
              reg_dat_we_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (guard_expired) begin
            state_q      <= ST_CFG;
            reg_div_we_q <= 1'b1;
            reg_div_di_q <= div_val;
            div_ack_q    <= 1'b1;
            shadow_div_q <= div_val;
          end
        end
        ST_CFG:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  div_req_held: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == ST_DRAIN) |-> div_req);

  assign c0_ready   = gnt0;
  assign c1_ready   = gnt1;
  assign div_ack    = div_ack_q;
  assign fifo_level = fifo_lvl;
  assign tx_idle    = fifo_empty && guard_expired && (state_q == ST_IDLE);
  assign reg_div_we = reg_div_we_q;
  assign reg_div_di = reg_div_di_q;
  assign reg_dat_we = reg_dat_we_q;
  assign reg_dat_di = reg_dat_di_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: per-cycle vector table plus hand sequences for guard timing and reset.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        c0_valid, c1_valid, c0_ready, c1_ready;
  logic [7:0]  c0_data, c1_data;
  logic        div_req, div_ack;
  logic [31:0] div_val;
  logic [3:0]  fifo_level;
  logic        tx_idle;
  logic        reg_div_we, reg_dat_we, reg_dat_wait;
  logic [31:0] reg_div_di;
  logic [7:0]  reg_dat_di;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(.CLKDIV(139), .FIFO_DEPTH(8), .GUARD_BITS(11)) dut (
    .clk(clk), .resetn(resetn),
    .c0_valid(c0_valid), .c0_data(c0_data), .c0_ready(c0_ready),
    .c1_valid(c1_valid), .c1_data(c1_data), .c1_ready(c1_ready),
    .div_req(div_req), .div_val(div_val), .div_ack(div_ack),
    .fifo_level(fifo_level), .tx_idle(tx_idle),
    .reg_div_we(reg_div_we), .reg_div_di(reg_div_di),
    .reg_dat_we(reg_dat_we), .reg_dat_di(reg_dat_di), .reg_dat_wait(reg_dat_wait)
  );

  typedef struct {
    logic       c0v; logic [7:0] c0d;
    logic       c1v; logic [7:0] c1d;
    logic       wt;  logic       dreq;
    logic       e_c0r; logic e_c1r; logic e_we;
    logic [7:0] e_di; logic [3:0] e_lvl;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic c0v, input logic [7:0] c0d, input logic c1v, input logic [7:0] c1d,
                     input logic wt, input logic dreq, input logic e_c0r, input logic e_c1r,
                     input logic e_we, input logic [7:0] e_di, input logic [3:0] e_lvl);
    vec_t v;
    v.c0v = c0v; v.c0d = c0d; v.c1v = c1v; v.c1d = c1d; v.wt = wt; v.dreq = dreq;
    v.e_c0r = e_c0r; v.e_c1r = e_c1r; v.e_we = e_we; v.e_di = e_di; v.e_lvl = e_lvl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    c0_valid = 0; c0_data = 0; c1_valid = 0; c1_data = 0;
    div_req = 0; div_val = 0; reg_dat_wait = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      c0_valid = vecs[i].c0v; c0_data = vecs[i].c0d;
      c1_valid = vecs[i].c1v; c1_data = vecs[i].c1d;
      reg_dat_wait = vecs[i].wt; div_req = vecs[i].dreq; div_val = 32'd20;
      #1;
      chk($sformatf("v%0d c0_ready", i), c0_ready, vecs[i].e_c0r);
      chk($sformatf("v%0d c1_ready", i), c1_ready, vecs[i].e_c1r);
      chk($sformatf("v%0d reg_dat_we", i), reg_dat_we, vecs[i].e_we);
      chk($sformatf("v%0d fifo_level", i), fifo_level, vecs[i].e_lvl);
      if (vecs[i].e_we) chk($sformatf("v%0d reg_dat_di", i), reg_dat_di, vecs[i].e_di);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!tx_idle && n < 5000) begin
      @(negedge clk); #1; n++;
    end
  endtask

  task automatic wait_ack(output int n, output logic any_we);
    n = 0; any_we = 0;
    while (!div_ack && n < 5000) begin
      @(negedge clk); #1; n++;
      if (reg_dat_we) any_we = 1;
    end
  endtask

  initial begin
    int s_sb, s_rr, s_bp, s_dv, s_rs, s_end, n;
    logic any_we;

    s_sb = vecs.size();
    add(1,8'h41,0,8'h00, 0,0, 1,0,0,8'h00,4'd0);
    add(0,8'h00,0,8'h00, 0,0, 0,0,0,8'h00,4'd1);
    add(0,8'h00,0,8'h00, 0,0, 0,0,1,8'h41,4'd1);
    add(0,8'h00,0,8'h00, 0,0, 0,0,0,8'h00,4'd0);
    s_rr = vecs.size();
    add(1,8'h10,1,8'h20, 0,0, 1,0,0,8'h00,4'd0);
    add(1,8'h11,1,8'h20, 0,0, 0,1,0,8'h00,4'd1);
    add(1,8'h11,1,8'h21, 0,0, 1,0,1,8'h10,4'd2);
    add(1,8'h12,1,8'h21, 0,0, 0,1,1,8'h20,4'd2);
    add(1,8'h12,1,8'h22, 0,0, 1,0,1,8'h11,4'd2);
    add(0,8'h00,0,8'h00, 0,0, 0,0,1,8'h21,4'd2);
    add(0,8'h00,0,8'h00, 0,0, 0,0,1,8'h12,4'd1);
    add(0,8'h00,0,8'h00, 0,0, 0,0,0,8'h00,4'd0);
    s_bp = vecs.size();
    add(0,8'h00,1,8'h30, 1,0, 0,1,0,8'h00,4'd0);
    add(0,8'h00,1,8'h31, 1,0, 0,1,0,8'h00,4'd1);
    for (int k = 2; k < 8; k++)
      add(0,8'h00,1,8'(8'h30 + k), 1,0, 0,1,1,8'h30,4'(k));
    add(0,8'h00,1,8'h38, 1,0, 0,0,1,8'h30,4'd8);
    add(0,8'h00,1,8'h38, 1,0, 0,0,1,8'h30,4'd8);
    add(0,8'h00,1,8'h38, 0,0, 0,1,1,8'h30,4'd8);
    add(1,8'h40,0,8'h00, 0,0, 1,0,1,8'h31,4'd8);
    add(0,8'h00,0,8'h00, 0,0, 0,0,1,8'h32,4'd8);
    for (int k = 3; k < 9; k++)
      add(0,8'h00,0,8'h00, 0,0, 0,0,1,8'(8'h30 + k),4'(10 - k));
    add(0,8'h00,0,8'h00, 0,0, 0,0,1,8'h40,4'd1);
    add(0,8'h00,0,8'h00, 0,0, 0,0,0,8'h00,4'd0);
    s_dv = vecs.size();
    add(1,8'h51,0,8'h00, 1,0, 1,0,0,8'h00,4'd0);
    add(1,8'h52,0,8'h00, 1,0, 1,0,0,8'h00,4'd1);
    add(1,8'h53,0,8'h00, 1,0, 1,0,1,8'h51,4'd2);
    add(0,8'h00,0,8'h00, 0,1, 0,0,1,8'h51,4'd3);
    s_rs = vecs.size();
    add(0,8'h00,1,8'h61, 1,0, 0,1,0,8'h00,4'd0);
    add(1,8'h62,0,8'h00, 1,0, 1,0,0,8'h00,4'd1);
    add(0,8'h00,0,8'h00, 1,0, 0,0,1,8'h61,4'd2);
    s_end = vecs.size();

    do_reset();
    #1;
    chk("reset reg_dat_we", reg_dat_we, 0);
    chk("reset reg_dat_di", reg_dat_di, 0);
    chk("reset reg_div_we", reg_div_we, 0);
    chk("reset reg_div_di", reg_div_di, 0);
    chk("reset div_ack", div_ack, 0);
    chk("reset fifo_level", fifo_level, 0);
    chk("reset tx_idle", tx_idle, 1);

    run(s_sb, s_rr);
    chk("single tx_idle before guard", tx_idle, 0);
    wait_idle(n);
    chk("single guard cycles", n, 1551);

    do_reset();
    run(s_rr, s_bp);

    do_reset();
    run(s_bp, s_dv);

    do_reset();
    run(s_dv, s_rs);
    wait_ack(n, any_we);
    chk("drain cycles to div_ack", n, 1553);
    chk("no reg_dat_we while draining", any_we, 0);
    chk("cfg reg_div_we", reg_div_we, 1);
    chk("cfg reg_div_di", reg_div_di, 20);
    div_req = 0;
    @(negedge clk); #1;
    chk("div_ack one cycle", div_ack, 0);
    chk("reg_div_we one cycle", reg_div_we, 0);
    chk("level after cfg", fifo_level, 2);
    @(negedge clk); #1;
    chk("resume byte2 we", reg_dat_we, 1);
    chk("resume byte2 di", reg_dat_di, 8'h52);
    @(negedge clk); #1;
    chk("resume byte3 di", reg_dat_di, 8'h53);
    @(negedge clk); #1;
    chk("resume done we", reg_dat_we, 0);
    wait_idle(n);
    chk("guard cycles new divider", n, 242);
    div_req = 1; div_val = 32'd139;
    wait_ack(n, any_we);
    chk("idle div_req latency", n, 2);
    chk("idle cfg reg_div_di", reg_div_di, 139);
    div_req = 0;

    do_reset();
    run(s_rs, s_end);
    #2;
    resetn = 0;
    #1;
    chk("async reset reg_dat_we", reg_dat_we, 0);
    chk("async reset fifo_level", fifo_level, 0);
    chk("async reset tx_idle", tx_idle, 1);
    @(negedge clk);
    resetn = 1;
    clear_inputs();
    c0_valid = 1; c0_data = 8'h70; c1_valid = 1; c1_data = 8'h71;
    #1;
    chk("tie after reset c0_ready", c0_ready, 1);
    chk("tie after reset c1_ready", c1_ready, 0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("level after post-reset push", fifo_level, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
